uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/tx_baud_counter.sv | 33 +++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive sides.
//   uart_state_t : frame-level FSM states
//   DATA_BITS    : payload bits per frame
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit (and of the idle line)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// tx_baud_counter: bit timer for the UART transmitter.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the count
//   load : restart the count at 0 (start of a new bit)
//   en   : count while high
//   tick : high on the last cycle of a bit (count == CLKS_PER_BIT-1)
module tx_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, optional even parity, one stop bit.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, aborts any frame
//   tx_en    : enables acceptance of new frames (does not abort a frame)
//   tx_start : single-cycle request to send 'data'
//   data     : byte to send, sampled only on acceptance
//   TX       : registered serial line, idle high
//   busy     : high while a frame is in flight
//   done     : one-cycle pulse on the last cycle of the stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       tx_start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       busy,
    output logic       done
);

    uart_state_t state, state_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic        par, par_n;
    logic        tx_q, tx_n;
    logic        tick;
    logic        accept;

    // The final stop-bit cycle doubles as the idle/done cycle, so a request
    // seen there starts the next frame with no gap between frames.
    assign done   = (state == STOP) && tick;
    assign busy   = (state != IDLE) && !done;
    assign accept = tx_start && tx_en && !busy;
    assign TX     = tx_q;

    tx_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .load(accept || tick),
        .en  (state != IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            par     <= 1'b0;
            tx_q    <= STOP_BIT;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_idx <= bit_idx_n;
            par     <= par_n;
            tx_q    <= tx_n;
        end
    end

    // TX is computed one cycle ahead so it leaves a flop; the value loaded
    // is the level of the bit that the next state represents.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        par_n     = par;
        tx_n      = tx_q;

        if (accept) begin
            state_n   = START;
            shreg_n   = data;
            par_n     = even_parity(data);
            bit_idx_n = '0;
            tx_n      = START_BIT;
        end else begin
            case (state)
                IDLE: begin
                    tx_n = STOP_BIT;
                end
                START: begin
                    if (tick) begin
                        state_n = DATA;
                        tx_n    = shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                state_n = PARITY;
                                tx_n    = par;
                            end else begin
                                state_n = STOP;
                                tx_n    = STOP_BIT;
                            end
                        end else begin
                            bit_idx_n = bit_idx + 3'd1;
                            shreg_n   = shreg >> 1;
                            tx_n      = shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_n = STOP;
                        tx_n    = STOP_BIT;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_n = IDLE;
                        tx_n    = STOP_BIT;
                    end
                end
                default: begin
                    state_n = IDLE;
                    tx_n    = STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_start(tx_start), .data(data),
        .TX(tx0), .busy(busy0), .done(done0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_p (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_start(tx_start), .data(data),
        .TX(tx1), .busy(busy1), .done(done1)
    );

    // frame[i] is the i-th bit on the line: start, d0..d7, [parity], stop, pad
    typedef struct {
        logic [7:0]  d;
        logic        par;
        int unsigned nbits;
        logic [0:10] frame;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tx_start = 1'b0; tx_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks TX/busy/done every cycle of one frame. Cycle c counts from the
    // acceptance edge; the frame ends with done on cycle nbits*CPB.
    task automatic run_frame(input int vi, input vec_t v, input logic start_it,
                             input logic chain, input logic [7:0] next_d,
                             input logic disturb);
        int unsigned len;
        logic t, b, dn;
        len = v.nbits * CPB;
        if (start_it) begin
            @(negedge clk);
            tx_start = 1'b1; data = v.d; tx_en = 1'b1;
        end
        @(posedge clk);
        for (int unsigned c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tx_start = 1'b0;
                data = ~v.d;
            end
            if (disturb && c == 10) begin tx_start = 1'b1; data = 8'hFF; end
            if (disturb && c == 11) tx_start = 1'b0;
            if (disturb && c == 20) tx_en = 1'b0;
            t  = v.par ? tx1 : tx0;
            b  = v.par ? busy1 : busy0;
            dn = v.par ? done1 : done0;
            chk($sformatf("tx v%0d c%0d", vi, c), t, v.frame[(c - 1) / CPB]);
            chk($sformatf("busy v%0d c%0d", vi, c), b, (c < len));
            chk($sformatf("done v%0d c%0d", vi, c), dn, (c == len));
            if (chain && c == len) begin
                tx_start = 1'b1; data = next_d;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 10, 11'b0_10100101_1_1};
        vecs[1] = '{8'h07, 1'b1, 11, 11'b0_11100000_1_1};
        vecs[2] = '{8'h3C, 1'b0, 10, 11'b0_00111100_1_1};
        vecs[3] = '{8'h00, 1'b1, 11, 11'b0_00000000_0_1};
        vecs[4] = '{8'hFF, 1'b1, 11, 11'b0_11111111_0_1};
        vecs[5] = '{8'h55, 1'b0, 10, 11'b0_10101010_1_1};
        vecs[6] = '{8'hAA, 1'b0, 10, 11'b0_01010101_1_1};

        // Reset state
        do_reset();
        chk("rst tx0", tx0, 1'b1);
        chk("rst busy0", busy0, 1'b0);
        chk("rst done0", done0, 1'b0);
        chk("rst tx1", tx1, 1'b1);
        chk("rst busy1", busy1, 1'b0);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_frame(i, vecs[i], 1'b1, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            chk($sformatf("idle tx v%0d", i), vecs[i].par ? tx1 : tx0, 1'b1);
            chk($sformatf("idle busy v%0d", i), vecs[i].par ? busy1 : busy0, 1'b0);
            chk($sformatf("idle done v%0d", i), vecs[i].par ? done1 : done0, 1'b0);
        end

        // Back-to-back 0x55 then 0xAA: request on the done cycle
        do_reset();
        run_frame(5, vecs[5], 1'b1, 1'b1, 8'hAA, 1'b0);
        run_frame(6, vecs[6], 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("b2b idle busy", busy0, 1'b0);
        chk("b2b idle tx", tx0, 1'b1);

        // Start request and data change mid-frame, tx_en dropped while busy
        do_reset();
        run_frame(0, vecs[0], 1'b1, 1'b0, 8'h00, 1'b1);
        for (int unsigned c = 0; c < 48; c++) begin
            @(negedge clk);
            chk($sformatf("no 2nd frame busy c%0d", c), busy0, 1'b0);
            chk($sformatf("no 2nd frame tx c%0d", c), tx0, 1'b1);
        end
        tx_en = 1'b1;

        // Reset during data bit 3 of 0x3C
        do_reset();
        @(negedge clk);
        tx_start = 1'b1; data = 8'h3C;
        @(negedge clk);
        tx_start = 1'b0;
        for (int unsigned c = 2; c < 18; c++) @(negedge clk);
        chk("pre-rst busy", busy0, 1'b1);
        chk("pre-rst tx bit3", tx0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort tx", tx0, 1'b1);
        chk("abort busy", busy0, 1'b0);
        chk("abort done", done0, 1'b0);
        rst = 1'b0;
        for (int unsigned c = 0; c < 48; c++) begin
            @(negedge clk);
            chk($sformatf("post-abort done c%0d", c), done0, 1'b0);
            chk($sformatf("post-abort busy c%0d", c), busy0, 1'b0);
        end
        run_frame(2, vecs[2], 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset wins over tx_start on the same edge
        do_reset();
        @(negedge clk);
        rst = 1'b1; tx_start = 1'b1; data = 8'h5A;
        @(negedge clk);
        rst = 1'b0; tx_start = 1'b0;
        chk("rst prio busy", busy0, 1'b0);
        chk("rst prio tx", tx0, 1'b1);
        @(negedge clk);
        chk("rst prio busy2", busy0, 1'b0);

        // tx_start with tx_en low is not accepted
        do_reset();
        @(negedge clk);
        tx_en = 1'b0; tx_start = 1'b1; data = 8'h00;
        for (int unsigned c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("en low busy c%0d", c), busy0, 1'b0);
            chk($sformatf("en low tx c%0d", c), tx0, 1'b1);
        end
        tx_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
